// File: rtl/prbs_pkg.sv
// PRBS9 polynomial constants and receiver FSM state encoding, shared by the
// modulator-side source and the receive-side BER checker.
package prbs_pkg;
  localparam int PRBS_LEN   = 9;
  localparam int PRBS_TAP_A = 8;  // x^9 term
  localparam int PRBS_TAP_B = 4;  // x^5 term

  typedef enum logic [1:0] {
    ST_SEED   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_SYNCED = 2'd2
  } state_t;
endpackage

// File: rtl/prbs_lfsr.sv
// Shift-left PRBS LFSR; new bit is either an external bit (seeding) or its own feedback.
// pred_o/next_o are combinational from the current state; state advances one step per shift_i.
module prbs_lfsr
  import prbs_pkg::*;
#(
  parameter int NBITS = PRBS_LEN
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             shift_i,
  input  logic             load_sel_i,
  input  logic             load_bit_i,
  output logic             pred_o,
  output logic [NBITS-1:0] next_o
);
  logic [NBITS-1:0] lfsr_q;
  logic [NBITS-1:0] lfsr_d;
  logic             in_bit;

  assign pred_o = lfsr_q[PRBS_TAP_A] ^ lfsr_q[PRBS_TAP_B];
  assign in_bit = load_sel_i ? load_bit_i : pred_o;
  assign lfsr_d = {lfsr_q[NBITS-2:0], in_bit};
  assign next_o = lfsr_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q <= '0;
    end else if (shift_i) begin
      lfsr_q <= lfsr_d;
    end
  end
endmodule

// File: rtl/prbs_ber_checker.sv
// PRBS9 receiver: self-syncs a local LFSR, then counts compared bits and errors (saturating).
// Outputs registered, one cycle after the strobe; no backpressure, every strobe is consumed.
module prbs_ber_checker
  import prbs_pkg::*;
#(
  parameter int NB_CNT   = 32,
  parameter int LOCK_LEN = 64,
  parameter int WIN_LEN  = 128,
  parameter int LOSS_TH  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic              i_bit,
  input  logic              i_clr_cnt,
  output logic              o_synced,
  output logic [NB_CNT-1:0] o_bit_cnt,
  output logic [NB_CNT-1:0] o_err_cnt,
  output logic              o_err
);
  localparam int LDW = $clog2(PRBS_LEN);
  localparam int LCW = $clog2(LOCK_LEN + 1);
  localparam int WCW = $clog2(WIN_LEN + 1);
  localparam int WEW = $clog2(LOSS_TH + 1);
  localparam logic [NB_CNT-1:0] CNT_MAX = '1;

  state_t                state_q;
  logic [LDW-1:0]        load_cnt_q;
  logic [LCW-1:0]        chk_cnt_q;
  logic [WCW-1:0]        win_cnt_q;
  logic [WEW-1:0]        win_err_q;
  logic [WEW-1:0]        win_err_inc;
  logic                  synced_q;
  logic                  err_q;
  logic [NB_CNT-1:0]     bit_cnt_q, bit_cnt_d;
  logic [NB_CNT-1:0]     err_cnt_q, err_cnt_d;
  logic                  pred;
  logic                  mismatch;
  logic [PRBS_LEN-1:0]   lfsr_next;

  prbs_lfsr #(.NBITS(PRBS_LEN)) u_lfsr (
    .clk_i      (i_clk),
    .rst_i      (i_rst),
    .shift_i    (i_valid),
    .load_sel_i (state_q == ST_SEED),
    .load_bit_i (i_bit),
    .pred_o     (pred),
    .next_o     (lfsr_next)
  );

  assign mismatch    = i_bit ^ pred;
  assign win_err_inc = win_err_q + WEW'(mismatch);

  // Clear has priority over a same-cycle SYNCED strobe; that strobe is dropped from the counts.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    err_cnt_d = err_cnt_q;
    if (i_clr_cnt) begin
      bit_cnt_d = '0;
      err_cnt_d = '0;
    end else if (i_valid && state_q == ST_SYNCED) begin
      if (bit_cnt_q != CNT_MAX) bit_cnt_d = bit_cnt_q + 1'b1;
      if (mismatch && err_cnt_q != CNT_MAX) err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_SEED;
      load_cnt_q <= '0;
      chk_cnt_q  <= '0;
      win_cnt_q  <= '0;
      win_err_q  <= '0;
      synced_q   <= 1'b0;
      err_q      <= 1'b0;
      bit_cnt_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      err_cnt_q <= err_cnt_d;
      err_q     <= 1'b0;
      if (i_valid) begin
        unique case (state_q)
          ST_SEED: begin
            if (load_cnt_q == LDW'(PRBS_LEN - 1)) begin
              load_cnt_q <= '0;
              // An all-zero register would self-feed zeros forever; keep seeding instead.
              if (lfsr_next != '0) begin
                state_q   <= ST_CHECK;
                chk_cnt_q <= '0;
              end
            end else begin
              load_cnt_q <= load_cnt_q + 1'b1;
            end
          end
          ST_CHECK: begin
            if (mismatch) begin
              err_q      <= 1'b1;
              state_q    <= ST_SEED;
              load_cnt_q <= '0;
            end else if (chk_cnt_q == LCW'(LOCK_LEN - 1)) begin
              state_q   <= ST_SYNCED;
              synced_q  <= 1'b1;
              win_cnt_q <= '0;
              win_err_q <= '0;
            end else begin
              chk_cnt_q <= chk_cnt_q + 1'b1;
            end
          end
          ST_SYNCED: begin
            err_q <= mismatch;
            if (win_err_inc >= WEW'(LOSS_TH)) begin
              state_q    <= ST_SEED;
              synced_q   <= 1'b0;
              load_cnt_q <= '0;
            end else if (win_cnt_q == WCW'(WIN_LEN - 1)) begin
              win_cnt_q <= '0;
              win_err_q <= '0;
            end else begin
              win_cnt_q <= win_cnt_q + 1'b1;
              win_err_q <= win_err_inc;
            end
          end
          default: state_q <= ST_SEED;
        endcase
      end
    end
  end

  assign o_synced  = synced_q;
  assign o_err     = err_q;
  assign o_bit_cnt = bit_cnt_q;
  assign o_err_cnt = err_cnt_q;
endmodule

// File: tb/tb_prbs_ber_checker.sv
// Bench for prbs_ber_checker: PRBS9 stream generator, queue-based reference receiver,
// scenario tasks with inline comparisons; a second NB_CNT=4 instance shares all inputs.
module tb_prbs_ber_checker;
  logic        clk = 1'b0;
  logic        i_rst, i_valid, i_bit, i_clr_cnt;
  logic        o_synced, o_err;
  logic [31:0] o_bit_cnt, o_err_cnt;
  logic        s_synced, s_err;
  logic [3:0]  s_bit_cnt, s_err_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int obs_pulses = 0;

  always #5 clk = ~clk;

  prbs_ber_checker dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_bit(i_bit), .i_clr_cnt(i_clr_cnt),
    .o_synced(o_synced), .o_bit_cnt(o_bit_cnt), .o_err_cnt(o_err_cnt), .o_err(o_err)
  );

  prbs_ber_checker #(.NB_CNT(4)) dut4 (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_bit(i_bit), .i_clr_cnt(i_clr_cnt),
    .o_synced(s_synced), .o_bit_cnt(s_bit_cnt), .o_err_cnt(s_err_cnt), .o_err(s_err)
  );

  // ---------------- reference receiver ----------------
  localparam int M_SEED = 0, M_CHECK = 1, M_SYNCED = 2;
  int          m_mode, m_nload, m_nmatch, m_wpos, m_werr;
  bit          m_ref[$];   // last 9 bits of the reference sequence, oldest first
  bit          m_synced, m_err_pulse;
  logic [31:0] m_bit, m_err;
  logic [3:0]  m_bit4, m_err4;

  function automatic void model_reset();
    m_mode = M_SEED; m_nload = 0; m_nmatch = 0; m_wpos = 0; m_werr = 0;
    m_ref = {};
    for (int i = 0; i < 9; i++) m_ref.push_back(1'b0);
    m_synced = 0; m_err_pulse = 0;
    m_bit = 0; m_err = 0; m_bit4 = 0; m_err4 = 0;
  endfunction

  function automatic void ref_push(input bit x);
    m_ref.push_back(x);
    void'(m_ref.pop_front());
  endfunction

  function automatic void model_update(input bit v, input bit b, input bit clr);
    bit p, mis, zero;
    m_err_pulse = 0;
    if (clr) begin m_bit = 0; m_err = 0; m_bit4 = 0; m_err4 = 0; end
    if (!v) return;
    // b[n] = b[n-9] ^ b[n-5]: with 9 history bits, those are entries 0 and 4
    p = m_ref[0] ^ m_ref[4];
    mis = (b != p);
    case (m_mode)
      M_SEED: begin
        ref_push(b);
        m_nload++;
        if (m_nload == 9) begin
          m_nload = 0;
          zero = 1;
          foreach (m_ref[i]) if (m_ref[i]) zero = 0;
          if (!zero) begin m_mode = M_CHECK; m_nmatch = 0; end
        end
      end
      M_CHECK: begin
        ref_push(p);
        if (mis) begin
          m_err_pulse = 1; m_mode = M_SEED; m_nload = 0;
        end else begin
          m_nmatch++;
          if (m_nmatch == 64) begin m_mode = M_SYNCED; m_synced = 1; m_wpos = 0; m_werr = 0; end
        end
      end
      default: begin
        ref_push(p);
        m_err_pulse = mis;
        if (!clr) begin
          if (m_bit != 32'hFFFF_FFFF) m_bit++;
          if (mis && m_err != 32'hFFFF_FFFF) m_err++;
          if (m_bit4 != 4'hF) m_bit4++;
          if (mis && m_err4 != 4'hF) m_err4++;
        end
        m_werr += int'(mis);
        if (m_werr >= 16) begin
          m_mode = M_SEED; m_synced = 0; m_nload = 0;
        end else begin
          m_wpos++;
          if (m_wpos == 128) begin m_wpos = 0; m_werr = 0; end
        end
      end
    endcase
  endfunction

  // ---------------- PRBS9 transmit source, seeded 9'h1FF ----------------
  bit g_q[$];
  function automatic void gen_reset();
    g_q = {};
    for (int i = 0; i < 9; i++) g_q.push_back(1'b1);
  endfunction
  function automatic bit gen_bit();
    bit x;
    x = g_q[0] ^ g_q[4];
    g_q.push_back(x);
    void'(g_q.pop_front());
    return x;
  endfunction

  // ---------------- drivers ----------------
  task automatic step(input bit v, input bit b, input bit clr);
    i_valid = v; i_bit = b; i_clr_cnt = clr;
    @(posedge clk);
    model_update(v, b, clr);
    #1;
    if (o_err === 1'b1) obs_pulses++;
    i_valid = 1'b0; i_clr_cnt = 1'b0;
  endtask

  task automatic strobe(input bit b, input int gap);
    step(1'b1, b, 1'b0);
    repeat (gap) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic apply_reset();
    i_rst = 1'b1; i_valid = 1'b0; i_clr_cnt = 1'b0;
    @(posedge clk); #1;
    i_rst = 1'b0;
    model_reset();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    i_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      i_valid = 1'b1; i_bit = 1'($urandom); i_clr_cnt = 1'($urandom);
      @(posedge clk);
    end
    #1;
    n_checks++; if (o_synced !== 1'b0) begin n_fail++; $display("FAIL reset_synced: got %b want 0", o_synced); end
    n_checks++; if (o_bit_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_bit_cnt: got %0d want 0", o_bit_cnt); end
    n_checks++; if (o_err_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_err_cnt: got %0d want 0", o_err_cnt); end
    n_checks++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL reset_o_err: got %b want 0", o_err); end
    i_rst = 1'b0; i_valid = 1'b0; i_clr_cnt = 1'b0;
    model_reset();
  endtask

  task automatic test_lock_clean();
    int p0;
    gen_reset();
    for (int s = 1; s <= 73; s++) begin
      strobe(gen_bit(), 7);
      if (s == 72) begin
        n_checks++; if (o_synced !== 1'b0) begin n_fail++; $display("FAIL lock_early: got %b want 0 after 72 strobes", o_synced); end
      end
    end
    n_checks++; if (o_synced !== 1'b1) begin n_fail++; $display("FAIL lock_73: got %b want 1 after 73 strobes", o_synced); end
    p0 = obs_pulses;
    for (int s = 0; s < 1000; s++) strobe(gen_bit(), 7);
    n_checks++; if (o_bit_cnt !== 32'd1000) begin n_fail++; $display("FAIL clean_bit_cnt: got %0d want 1000", o_bit_cnt); end
    n_checks++; if (o_err_cnt !== 32'd0) begin n_fail++; $display("FAIL clean_err_cnt: got %0d want 0", o_err_cnt); end
    n_checks++; if (obs_pulses - p0 !== 0) begin n_fail++; $display("FAIL clean_pulses: got %0d want 0", obs_pulses - p0); end
    n_checks++; if (s_bit_cnt !== 4'd15) begin n_fail++; $display("FAIL sat4_bit_cnt: got %0d want 15", s_bit_cnt); end
  endtask

  task automatic test_sparse_flips();
    int pos, lost, bad_pulse, p0;
    bit b, f;
    lost = 0; bad_pulse = 0; p0 = obs_pulses;
    for (int k = 0; k < 10; k++) begin
      pos = $urandom_range(0, 99);
      for (int j = 0; j < 100; j++) begin
        b = gen_bit();
        f = (j == pos);
        step(1'b1, b ^ f, 1'b0);
        if (o_err !== f) bad_pulse++;
        if (o_synced !== 1'b1) lost++;
        repeat ($urandom_range(1, 3)) step(1'b0, 1'b0, 1'b0);
      end
    end
    n_checks++; if (o_err_cnt !== 32'd10) begin n_fail++; $display("FAIL flips_err_cnt: got %0d want 10", o_err_cnt); end
    n_checks++; if (o_bit_cnt !== 32'd2000) begin n_fail++; $display("FAIL flips_bit_cnt: got %0d want 2000", o_bit_cnt); end
    n_checks++; if (lost !== 0) begin n_fail++; $display("FAIL flips_sync_kept: %0d strobes unsynced, want 0", lost); end
    n_checks++; if (bad_pulse !== 0) begin n_fail++; $display("FAIL flips_err_pulse: %0d strobes with wrong o_err, want 0", bad_pulse); end
    n_checks++; if (obs_pulses - p0 !== 10) begin n_fail++; $display("FAIL flips_pulses: got %0d want 10", obs_pulses - p0); end
  endtask

  task automatic test_loss_relock();
    int n, m, trace_bad;
    bit b;
    n = 0; m = 0; trace_bad = 0;
    while (o_synced === 1'b1 && n < 100) begin
      b = gen_bit();
      strobe(~b, 1);
      n++;
      if (o_synced !== m_synced) trace_bad++;
    end
    // 80 strobes into the current window, holding at most one earlier flip
    n_checks++; if (n < 15 || n > 16) begin n_fail++; $display("FAIL loss_point: fell after %0d inverted strobes, want 15..16", n); end
    n_checks++; if (trace_bad !== 0) begin n_fail++; $display("FAIL loss_trace: %0d strobes disagree with model, want 0", trace_bad); end
    n_checks++; if (o_err_cnt !== 32'(10 + n)) begin n_fail++; $display("FAIL loss_err_cnt: got %0d want %0d", o_err_cnt, 10 + n); end
    while (o_synced !== 1'b1 && m < 200) begin
      strobe(gen_bit(), 1);
      m++;
    end
    n_checks++; if (m !== 73) begin n_fail++; $display("FAIL relock_len: got %0d strobes want 73", m); end
    n_checks++; if (o_bit_cnt !== 32'(2000 + n)) begin n_fail++; $display("FAIL relock_bit_cnt: got %0d want %0d", o_bit_cnt, 2000 + n); end
    n_checks++; if (o_err_cnt !== 32'(10 + n)) begin n_fail++; $display("FAIL relock_err_cnt: got %0d want %0d", o_err_cnt, 10 + n); end
  endtask

  task automatic test_check_error();
    int p0, ever_sync;
    bit b;
    apply_reset(); gen_reset();
    p0 = obs_pulses; ever_sync = 0;
    for (int s = 1; s <= 40; s++) begin
      b = gen_bit();
      if (s == 30) b = ~b;
      step(1'b1, b, 1'b0);
      if (s == 30) begin
        n_checks++; if (o_err !== 1'b1) begin n_fail++; $display("FAIL check_err_pulse: got %b want 1 at strobe 30", o_err); end
      end
      if (o_synced === 1'b1) ever_sync++;
      step(1'b0, 1'b0, 1'b0);
    end
    n_checks++; if (ever_sync !== 0) begin n_fail++; $display("FAIL check_err_sync: synced on %0d strobes, want 0", ever_sync); end
    n_checks++; if (obs_pulses - p0 !== 1) begin n_fail++; $display("FAIL check_err_pulses: got %0d want 1", obs_pulses - p0); end
    n_checks++; if (o_bit_cnt !== 32'd0 || o_err_cnt !== 32'd0) begin n_fail++; $display("FAIL check_err_counts: got %0d/%0d want 0/0", o_bit_cnt, o_err_cnt); end
  endtask

  task automatic test_all_zero();
    int p0, ever_sync, trace_bad;
    apply_reset(); gen_reset();
    p0 = obs_pulses; ever_sync = 0; trace_bad = 0;
    for (int s = 0; s < 200; s++) begin
      strobe(1'b0, $urandom_range(0, 3));
      if (o_synced === 1'b1) ever_sync++;
    end
    n_checks++; if (ever_sync !== 0) begin n_fail++; $display("FAIL zero_sync: synced on %0d strobes, want 0", ever_sync); end
    n_checks++; if (obs_pulses - p0 !== 0) begin n_fail++; $display("FAIL zero_pulses: got %0d want 0", obs_pulses - p0); end
    n_checks++; if (o_bit_cnt !== 32'd0) begin n_fail++; $display("FAIL zero_bit_cnt: got %0d want 0", o_bit_cnt); end
    // Live stream after the zero run, starting mid-load-count
    for (int s = 0; s < 200; s++) begin
      strobe(gen_bit(), 1);
      if (o_synced !== m_synced || o_err !== m_err_pulse) trace_bad++;
    end
    n_checks++; if (trace_bad !== 0 || o_synced !== 1'b1) begin n_fail++; $display("FAIL zero_then_lock: %0d model disagreements, synced %b want 0 and 1", trace_bad, o_synced); end
  endtask

  task automatic test_clear_and_reset();
    int m;
    bit b;
    for (int s = 0; s < 20; s++) strobe(gen_bit(), 1);
    step(1'b1, gen_bit(), 1'b1);
    n_checks++; if (o_bit_cnt !== 32'd0 || o_err_cnt !== 32'd0) begin n_fail++; $display("FAIL clr_with_strobe: got %0d/%0d want 0/0", o_bit_cnt, o_err_cnt); end
    n_checks++; if (s_bit_cnt !== 4'd0) begin n_fail++; $display("FAIL clr_with_strobe4: got %0d want 0", s_bit_cnt); end
    strobe(gen_bit(), 1);
    n_checks++; if (o_bit_cnt !== 32'd1) begin n_fail++; $display("FAIL clr_then_count: got %0d want 1", o_bit_cnt); end
    step(1'b0, 1'b0, 1'b1);
    n_checks++; if (o_bit_cnt !== 32'd0) begin n_fail++; $display("FAIL clr_idle: got %0d want 0", o_bit_cnt); end
    b = gen_bit();
    step(1'b1, ~b, 1'b0);
    n_checks++; if (o_err !== 1'b1 || o_err_cnt !== 32'd1 || o_bit_cnt !== 32'd1) begin n_fail++; $display("FAIL synced_err: got err %b cnt %0d/%0d want 1 1/1", o_err, o_err_cnt, o_bit_cnt); end
    step(1'b0, 1'b0, 1'b0);
    n_checks++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL err_width: got %b want 0 one cycle later", o_err); end
    i_rst = 1'b1; i_valid = 1'b1; i_bit = gen_bit();
    @(posedge clk); #1;
    i_rst = 1'b0; i_valid = 1'b0;
    model_reset();
    n_checks++; if (o_synced !== 1'b0 || o_bit_cnt !== 32'd0 || o_err_cnt !== 32'd0) begin n_fail++; $display("FAIL midrun_reset: got %b %0d/%0d want 0 0/0", o_synced, o_bit_cnt, o_err_cnt); end
    m = 0;
    while (o_synced !== 1'b1 && m < 200) begin strobe(gen_bit(), 1); m++; end
    n_checks++; if (m !== 73) begin n_fail++; $display("FAIL reset_relock_len: got %0d want 73", m); end
  endtask

  task automatic test_saturation();
    int f;
    bit b, fl;
    f = 0;
    for (int s = 0; s < 20; s++) begin
      b = gen_bit();
      fl = (f < 10) && ($urandom_range(0, 3) == 0);
      f += int'(fl);
      strobe(b ^ fl, 1);
    end
    n_checks++; if (s_bit_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_bit_cnt4: got %0d want 15", s_bit_cnt); end
    n_checks++; if (s_err_cnt !== 4'(f)) begin n_fail++; $display("FAIL sat_err_cnt4: got %0d want %0d", s_err_cnt, f); end
    n_checks++; if (o_bit_cnt !== 32'd20 || o_err_cnt !== 32'(f)) begin n_fail++; $display("FAIL sat_wide_counts: got %0d/%0d want 20/%0d", o_bit_cnt, o_err_cnt, f); end
  endtask

  task automatic test_random();
    logic [73:0] got, exp;
    bit v, b, clr;
    for (int c = 0; c < 4000; c++) begin
      v = ($urandom_range(0, 2) == 0);
      b = v ? (gen_bit() ^ ($urandom_range(0, 40) == 0)) : 1'($urandom);
      clr = ($urandom_range(0, 299) == 0);
      step(v, b, clr);
      got = {o_synced, o_err, o_bit_cnt, o_err_cnt, s_bit_cnt, s_err_cnt};
      exp = {m_synced, m_err_pulse, m_bit, m_err, m_bit4, m_err4};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        if (n_fail < 8) $display("FAIL random_cycle %0d: got %h want %h", c, got, exp);
      end
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1'b0; i_valid = 1'b0; i_bit = 1'b0; i_clr_cnt = 1'b0;
    model_reset(); gen_reset();
    test_reset();
    test_lock_clean();
    test_sparse_flips();
    test_loss_relock();
    test_check_error();
    test_all_zero();
    test_clear_and_reset();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
